digital_theremin_pio_in: RTL and testbench



---
 rtl/digital_theremin_pio_in.sv | 109 ++++++++++
 tb/tb_digital_theremin_pio_in.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/digital_theremin_pio_in.sv
// Avalon-MM input PIO: synchronized, per-bit debounced inputs with edge capture and a
// maskable level interrupt. Read data is registered, giving one cycle of read latency.
module digital_theremin_pio_in #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] ec_q, ec_d;
    logic [WIDTH-1:0] edge_det, clr;
    logic [CntW-1:0]  cnt_q [WIDTH];
    logic [CntW-1:0]  cnt_d [WIDTH];
    logic [31:0]      rdata_d;
    logic             wr_en;

    assign wr_en = chipselect & ~write_n;

    // A bit is accepted only after the synchronized value differs for DEBOUNCE_CYCLES cycles.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_det = stable_q & ~prev_q;
            1:       edge_det = ~stable_q & prev_q;
            default: edge_det = stable_q ^ prev_q;
        endcase
    end

    always_comb begin
        mask_d = mask_q;
        clr    = '0;
        if (wr_en && address == 2'd2) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == 2'd3) begin
            clr = writedata[WIDTH-1:0];
        end
        // An edge arriving with its own clear must survive.
        ec_d = (ec_q & ~clr) | edge_det;
    end

    always_comb begin
        rdata_d = '0;
        unique case (address)
            2'd0: rdata_d[WIDTH-1:0] = stable_q;
            2'd1: rdata_d = '0;
            2'd2: rdata_d[WIDTH-1:0] = mask_q;
            2'd3: rdata_d[WIDTH-1:0] = ec_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            prev_q   <= '0;
            mask_q   <= '0;
            ec_q     <= '0;
            readdata <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= in_port;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            mask_q   <= mask_d;
            ec_q     <= ec_d;
            readdata <= rdata_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign irq = |(ec_q & mask_q);

endmodule

// File: tb/tb_digital_theremin_pio_in.sv
// Directed bench for digital_theremin_pio_in: three builds (rising, falling, any edge) share
// one bus and input port; a vector table covers the basic flow, hand sequences the corners.
module tb_digital_theremin_pio_in;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [3:0]  in_port = '0;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    digital_theremin_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0)
    );
    digital_theremin_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd1), .irq(irq1)
    );
    digital_theremin_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd2), .irq(irq2)
    );

    typedef struct {
        logic [3:0]  in;
        logic [1:0]  addr;
        logic        wr;
        logic [31:0] wd;
        logic [31:0] rd0, rd1, rd2;
        logic        irq0, irq1, irq2;
    } vec_t;

    vec_t tbl [27];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [1:0] a, input logic wr, input logic [31:0] wd);
        address    = a;
        chipselect = 1'b1;
        write_n    = ~wr;
        writedata  = wd;
        step();
        write_n    = 1'b1;
    endtask

    task automatic chk_all(input string name, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2);
        chk({name, "_rise"}, rd0, e0);
        chk({name, "_fall"}, rd1, e1);
        chk({name, "_any"}, rd2, e2);
    endtask

    initial begin
        //             in    addr  wr    wd            rd0    rd1    rd2    irq0  irq1  irq2
        tbl[0]  = '{4'h0, 2'd0, 1'b0, 32'h0,        32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{4'h0, 2'd1, 1'b0, 32'h0,        32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{4'h0, 2'd2, 1'b0, 32'h0,        32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{4'h0, 2'd3, 1'b0, 32'h0,        32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{4'h0, 2'd2, 1'b1, 32'hFFFFFFF0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{4'h0, 2'd2, 1'b0, 32'h0,        32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
        for (int i = 6; i < 12; i++) begin
            tbl[i] = '{4'h1, 2'd0, 1'b0, 32'h0,     32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
        end
        tbl[12] = '{4'h1, 2'd0, 1'b0, 32'h0,        32'h1, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{4'h1, 2'd3, 1'b0, 32'h0,        32'h1, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{4'h1, 2'd2, 1'b1, 32'h1,        32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1};
        tbl[15] = '{4'h1, 2'd2, 1'b0, 32'h0,        32'h1, 32'h1, 32'h1, 1'b1, 1'b0, 1'b1};
        tbl[16] = '{4'h1, 2'd3, 1'b1, 32'h1,        32'h1, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{4'h1, 2'd3, 1'b0, 32'h0,        32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{4'h1, 2'd0, 1'b1, 32'h0,        32'h1, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0};
        for (int i = 19; i < 25; i++) begin
            tbl[i] = '{4'h0, 2'd0, 1'b0, 32'h0,     32'h1, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0};
        end
        tbl[25] = '{4'h0, 2'd0, 1'b0, 32'h0,        32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1};
        tbl[26] = '{4'h0, 2'd3, 1'b0, 32'h0,        32'h0, 32'h1, 32'h1, 1'b0, 1'b1, 1'b1};

        #1 reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            in_port = tbl[i].in;
            bus(tbl[i].addr, tbl[i].wr, tbl[i].wd);
            chk($sformatf("vec%0d_rd_rise", i), rd0, tbl[i].rd0);
            chk($sformatf("vec%0d_rd_fall", i), rd1, tbl[i].rd1);
            chk($sformatf("vec%0d_rd_any", i), rd2, tbl[i].rd2);
            chk($sformatf("vec%0d_irq_rise", i), 32'(irq0), 32'(tbl[i].irq0));
            chk($sformatf("vec%0d_irq_fall", i), 32'(irq1), 32'(tbl[i].irq1));
            chk($sformatf("vec%0d_irq_any", i), 32'(irq2), 32'(tbl[i].irq2));
        end

        // Short glitch on bit 2 must never be accepted.
        bus(2'd3, 1'b1, 32'hF);
        in_port = 4'h4;
        repeat (3) bus(2'd0, 1'b0, 32'h0);
        in_port = 4'h0;
        for (int i = 0; i < 10; i++) begin
            bus(2'd0, 1'b0, 32'h0);
            chk($sformatf("glitch_data%0d", i), rd0, 32'h0);
        end
        bus(2'd3, 1'b0, 32'h0);
        bus(2'd3, 1'b0, 32'h0);
        chk_all("glitch_ec", 32'h0, 32'h0, 32'h0);

        // Four-cycle pulse is just long enough.
        in_port = 4'h4;
        repeat (4) bus(2'd0, 1'b0, 32'h0);
        in_port = 4'h0;
        bus(2'd0, 1'b0, 32'h0);
        bus(2'd0, 1'b0, 32'h0);
        chk("pulse_data_early", rd0, 32'h0);
        bus(2'd0, 1'b0, 32'h0);
        chk("pulse_data", rd0, 32'h4);
        repeat (3) bus(2'd0, 1'b0, 32'h0);
        chk("pulse_data_hold", rd0, 32'h4);
        bus(2'd0, 1'b0, 32'h0);
        chk("pulse_back", rd0, 32'h0);
        bus(2'd3, 1'b0, 32'h0);
        chk_all("pulse_ec", 32'h4, 32'h4, 32'h4);

        // Clear of bit 1 coincides with a newly detected rising edge on bit 1.
        bus(2'd3, 1'b1, 32'hF);
        in_port = 4'h2;
        repeat (8) bus(2'd0, 1'b0, 32'h0);
        in_port = 4'h0;
        repeat (8) bus(2'd0, 1'b0, 32'h0);
        in_port = 4'h2;
        repeat (6) bus(2'd0, 1'b0, 32'h0);
        bus(2'd3, 1'b1, 32'h2);
        bus(2'd3, 1'b0, 32'h0);
        chk_all("w1c_collide", 32'h2, 32'h0, 32'h2);
        chk("irq_masked", 32'(irq0), 32'h0);

        // Asynchronous reset in the middle of a debounce.
        bus(2'd2, 1'b1, 32'hF);
        bus(2'd3, 1'b0, 32'h0);
        chk("irq_unmasked", 32'(irq0), 32'h1);
        chk("pre_reset_rd", rd0, 32'h2);
        in_port = 4'h8;
        repeat (3) bus(2'd0, 1'b0, 32'h0);
        #2 reset_n = 1'b0;
        #1;
        chk_all("async_reset_rd", 32'h0, 32'h0, 32'h0);
        chk("async_reset_irq", {29'h0, irq0, irq1, irq2}, 32'h0);
        #1 reset_n = 1'b1;
        address = 2'd0;
        repeat (6) step();
        chk("restart_early", rd0, 32'h0);
        step();
        chk("restart_data", rd0, 32'h8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
